// File: rtl/i2c_mem_arbiter.sv
// Arbitrates one single-port register memory between the I2C path and a local port.
// I2C has priority; a starvation counter forces a local grant after STARVE_LIMIT wins.
module i2c_mem_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_i2c_req,
   input  logic              i_i2c_we,
   input  logic [ADDR_W-1:0] i_i2c_addr,
   input  logic [DATA_W-1:0] i_i2c_wdata,
   output logic              o_i2c_ack,
   output logic [DATA_W-1:0] o_i2c_rdata,
   input  logic              i_loc_req,
   input  logic              i_loc_we,
   input  logic [ADDR_W-1:0] i_loc_addr,
   input  logic [DATA_W-1:0] i_loc_wdata,
   output logic              o_loc_ack,
   output logic [DATA_W-1:0] o_loc_rdata,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_hold_clock_low
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_IGNT = 3'd1;
   localparam logic [2:0] S_ICAP = 3'd2;
   localparam logic [2:0] S_IACK = 3'd3;
   localparam logic [2:0] S_LGNT = 3'd4;
   localparam logic [2:0] S_LCAP = 3'd5;
   localparam logic [2:0] S_LACK = 3'd6;

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] SLIM = CW'(STARVE_LIMIT);

   logic [2:0]        r_state;
   logic [CW-1:0]     r_starve;
   logic              r_acc_we;
   logic              r_i2c_ack;
   logic              r_loc_ack;
   logic [DATA_W-1:0] r_i2c_rdata;
   logic [DATA_W-1:0] r_loc_rdata;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_hold;

   logic [2:0] w_next;
   logic       w_igrant;
   logic       w_lgrant;
   logic       w_lside;

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE: begin
            if (i_i2c_req && (!i_loc_req || r_starve != SLIM))
               w_next = S_IGNT;
            else if (i_loc_req)
               w_next = S_LGNT;
            else
               w_next = S_IDLE;
         end
         S_IGNT:  w_next = S_ICAP;
         S_ICAP:  w_next = S_IACK;
         S_IACK:  w_next = S_IDLE;
         S_LGNT:  w_next = S_LCAP;
         S_LCAP:  w_next = S_LACK;
         S_LACK:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_igrant = (r_state == S_IDLE) && (w_next == S_IGNT);
   assign w_lgrant = (r_state == S_IDLE) && (w_next == S_LGNT);
   assign w_lside  = (w_next == S_LGNT) || (w_next == S_LCAP) ||
                     (w_next == S_LACK);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_starve    <= '0;
         r_acc_we    <= 1'b0;
         r_i2c_ack   <= 1'b0;
         r_loc_ack   <= 1'b0;
         r_i2c_rdata <= '0;
         r_loc_rdata <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_hold      <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_mem_en  <= w_igrant || w_lgrant;
         r_mem_we  <= (w_igrant && i_i2c_we) || (w_lgrant && i_loc_we);
         r_i2c_ack <= (w_next == S_IACK);
         r_loc_ack <= (w_next == S_LACK);
         r_hold    <= i_i2c_req && w_lside;
         if (w_igrant) begin
            r_mem_addr  <= i_i2c_addr;
            r_mem_wdata <= i_i2c_wdata;
            r_acc_we    <= i_i2c_we;
            if (!i_loc_req)
               r_starve <= '0;
            else if (r_starve != SLIM)
               r_starve <= r_starve + 1'b1;
         end else if (w_lgrant) begin
            r_mem_addr  <= i_loc_addr;
            r_mem_wdata <= i_loc_wdata;
            r_acc_we    <= i_loc_we;
            r_starve    <= '0;
         end
         // Synchronous-read data is valid only during the capture cycle.
         if (r_state == S_ICAP && !r_acc_we)
            r_i2c_rdata <= i_mem_rdata;
         if (r_state == S_LCAP && !r_acc_we)
            r_loc_rdata <= i_mem_rdata;
      end
   end

   assign o_i2c_ack        = r_i2c_ack;
   assign o_i2c_rdata      = r_i2c_rdata;
   assign o_loc_ack        = r_loc_ack;
   assign o_loc_rdata      = r_loc_rdata;
   assign o_mem_en         = r_mem_en;
   assign o_mem_we         = r_mem_we;
   assign o_mem_addr       = r_mem_addr;
   assign o_mem_wdata      = r_mem_wdata;
   assign o_hold_clock_low = r_hold;

endmodule
